// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-pair holding buffer feeding a 2*SLOT_W-bit frame shifter.
// Optional AUDIO_I2S_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module audio_i2s_tx #(
  parameter int DATA_W   = 24,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dout,
  output logic              underrun
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);
  localparam int FRAME_W = 2 * SLOT_W;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_W);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_W);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt, div_nxt;
  logic [BW-1:0]     bit_cnt, bit_nxt, pos;
  logic              hold_full, hold_nxt;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic [DATA_W-1:0] frame_l, frame_r, frame_l_nxt, frame_r_nxt, smp;
  logic              xfer, load;
  logic              bclk_nxt, lrck_nxt, dout_nxt, ready_nxt, under_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pll_locked)  state_nxt = RUN;
      RUN:     if (!pll_locked) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Everything below is evaluated on next-cycle values so the registered
  // outputs line up with the counters they describe.
  always_comb begin
    xfer        = s_valid && s_ready;
    load        = (state == RUN) && (div_cnt == '0) && (bit_cnt == '0);
    div_nxt     = '0;
    bit_nxt     = '0;
    hold_nxt    = 1'b0;
    frame_l_nxt = '0;
    frame_r_nxt = '0;
    if (state == RUN && state_nxt == RUN) begin
      div_nxt     = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      bit_nxt     = bit_cnt;
      if (div_cnt == DIV_LAST)
        bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      frame_l_nxt = frame_l;
      frame_r_nxt = frame_r;
      hold_nxt    = hold_full;
      if (load) begin
        frame_l_nxt = hold_full ? hold_l : '0;
        frame_r_nxt = hold_full ? hold_r : '0;
        hold_nxt    = 1'b0;
      end
      if (xfer) hold_nxt = 1'b1;
    end
  end

  always_comb begin
    lrck_nxt = (bit_nxt >= SLOT_B);
    pos      = lrck_nxt ? bit_nxt - SLOT_B : bit_nxt;
    smp      = lrck_nxt ? frame_r_nxt : frame_l_nxt;
    dout_nxt = 1'b0;
    for (int i = 0; i < DATA_W; i++)
      if (int'(pos) == DATA_W - i) dout_nxt = smp[i];
    bclk_nxt  = (div_nxt >= DIV_HALF);
    ready_nxt = (state_nxt == RUN) && !hold_nxt;
    // First frame after IDLE never counts as an underrun.
    under_nxt = (state == RUN) && (state_nxt == RUN) && (div_nxt == '0) &&
                (bit_nxt == '0) && !hold_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      frame_l   <= '0;
      frame_r   <= '0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_dout  <= 1'b0;
      s_ready   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      hold_full <= hold_nxt;
      if (xfer) begin
        hold_l <= s_left;
        hold_r <= s_right;
      end
      frame_l   <= frame_l_nxt;
      frame_r   <= frame_r_nxt;
      i2s_bclk  <= bclk_nxt;
      i2s_lrck  <= lrck_nxt;
      i2s_dout  <= dout_nxt;
      s_ready   <= ready_nxt;
      underrun  <= under_nxt;
    end
  end

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      underrun_cnt <= '0;
    else if (under_nxt && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: frame-level reference model plus a table of known frames.
module tb_audio_i2s_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_left = '0, s_right = '0;
  logic        i2s_bclk, i2s_lrck, i2s_dout, underrun;
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  audio_i2s_tx dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
    .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dout(i2s_dout),
    .underrun(underrun)
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] frame;
  } vec_t;

  int total = 0;
  int bad = 0;

  // Reference model: position in the run plus a queue of accepted pairs.
  bit          mrun = 1'b0;
  int          mk = 0;
  int          mucnt = 0;
  logic [47:0] mq[$];
  logic [23:0] cl = '0, cr = '0;
  logic [63:0] sh = '0;
  logic [63:0] capq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    logic er, eu, eb, el, ed;
    int bi, p;
    logic [23:0] smp;
    logic [47:0] pr;
    @(negedge clk);
    er = mrun && mq.size() == 0;
    eu = mrun && (mk % 384 == 0) && mk != 0 && mq.size() == 0;
    if (mrun && mk % 384 == 0) begin
      if (mq.size() != 0) begin
        pr = mq.pop_front();
        cl = pr[47:24];
        cr = pr[23:0];
      end else begin
        cl = '0;
        cr = '0;
      end
    end
    bi  = (mk / 6) % 64;
    p   = bi % 32;
    smp = (bi >= 32) ? cr : cl;
    eb  = mrun && (mk % 6) >= 3;
    el  = mrun && bi >= 32;
    ed  = mrun && p >= 1 && p <= 24 && smp[24 - p];
    if (eu && mucnt < 65535) mucnt++;
    chk("s_ready", 64'(s_ready), 64'(er));
    chk("underrun", 64'(underrun), 64'(eu));
    chk("bclk", 64'(i2s_bclk), 64'(eb));
    chk("lrck", 64'(i2s_lrck), 64'(el));
    chk("dout", 64'(i2s_dout), 64'(ed));
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    chk("underrun_cnt", 64'(underrun_cnt), 64'(mucnt));
`endif
    if (mrun && mk % 6 == 0) begin
      sh = {sh[62:0], i2s_dout};
      if (bi == 63) capq.push_back(sh);
    end
    if (mrun && s_valid && er) mq.push_back({s_left, s_right});
    if (!rst_n) mucnt = 0;
    if (!rst_n || !pll_locked) begin
      mrun = 1'b0;
      mk = 0;
      mq.delete();
    end else if (mrun) mk++;
    else begin
      mrun = 1'b1;
      mk = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!s_ready && n < 2000) begin
      tick();
      n++;
    end
    if (!s_ready) chk("ready_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   n, drop;
    tbl[0] = '{24'hA5F00F, 24'h123456, 64'h52F80780_091A2B00};
    tbl[1] = '{24'hFFFFFF, 24'h800001, 64'h7FFFFF80_40000080};
    tbl[2] = '{24'h000001, 24'h7FFFFE, 64'h00000080_3FFFFF00};
    tbl[3] = '{24'h000000, 24'h000000, 64'h00000000_00000000};

    repeat (4) tick();
    rst_n = 1'b1;
    pll_locked = 1'b1;

    // Known frames: frame 0 is silent, frame i+1 carries tbl[i].
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      s_valid = 1'b1;
      s_left = tbl[i].l;
      s_right = tbl[i].r;
      tick();
      s_valid = 1'b0;
    end
    n = 0;
    while (capq.size() < 5 && n < 5000) begin
      tick();
      n++;
    end
    if (capq.size() < 5) chk("frame_timeout", 64'(capq.size()), 64'd5);
    else begin
      chk("frame0_silent", capq[0], 64'd0);
      for (int i = 0; i < 4; i++) chk($sformatf("frame%0d", i + 1), capq[i + 1], tbl[i].frame);
    end
    repeat (500) tick();

    // Back-to-back supply: one pair per frame, no underrun.
    s_valid = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      s_left = 24'($urandom);
      s_right = 24'($urandom);
      tick();
    end
    s_valid = 1'b0;

    // Lock loss mid right slot, then relock.
    n = 0;
    while (!(mrun && (mk / 6) % 64 == 40 && mk % 6 == 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("bit40_timeout", 64'(n), 64'd0);
    pll_locked = 1'b0;
    repeat (10) tick();
    pll_locked = 1'b1;
    s_valid = 1'b1;
    s_left = 24'h5A5A5A;
    s_right = 24'hC3C3C3;
    tick();
    s_valid = 1'b0;
    repeat (800) tick();

    // Random traffic with occasional lock loss and reset.
    drop = 0;
    for (int i = 0; i < 20000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_left = 24'($urandom);
      s_right = 24'($urandom);
      if (drop == 0 && $urandom_range(0, 2999) == 0) drop = $urandom_range(1, 20);
      pll_locked = (drop == 0);
      if (drop > 0) drop--;
      rst_n = ($urandom_range(0, 9999) != 0);
      if (i > 4000 && i < 8000) s_valid = ($urandom_range(0, 2000) == 0);
      tick();
    end
    rst_n = 1'b1;
    pll_locked = 1'b1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
